// File: rtl/exec_ctl_if.sv
// Signal bundle for the exec_ctl instruction, ALU and memory channels, used by
// environment-side code that talks to an exec_ctl instance.
interface exec_ctl_if #(
  parameter int W = 32
);
  // Instruction channel: a word transfers on a rising edge where inst_valid && inst_ready;
  // the offering side may change the word freely while inst_ready is low.
  logic          inst_valid;
  logic          inst_ready;
  logic [15:0]   inst_word;
  logic [3:0]    alu_inst;
  logic [1:0]    alu_fmt;
  logic [W-1:0]  alu_reg0;
  logic [W-1:0]  alu_reg1;
  logic [W-1:0]  alu_ram;
  logic [W-1:0]  alu_wb;
  logic          mem_req;
  logic          mem_we;
  logic [W-1:0]  mem_addr;
  logic [W-1:0]  mem_wdata;
  logic          mem_ack;
  logic [W-1:0]  mem_rdata;
  logic          busy;

  modport master (
    input  inst_valid, inst_word, alu_wb, mem_ack, mem_rdata,
    output inst_ready, alu_inst, alu_fmt, alu_reg0, alu_reg1, alu_ram,
           mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    output inst_valid, inst_word, alu_wb, mem_ack, mem_rdata,
    input  inst_ready, alu_inst, alu_fmt, alu_reg0, alu_reg1, alu_ram,
           mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/exec_ctl.sv
// Instruction sequencer: owns the register file, feeds operands to an external ALU,
// issues one memory access for load/store ops and writes the ALU result back.
package exec_ctl_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_LDA  = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_CBR  = 4'hB;
  localparam logic [3:0] OP_SPEC = 4'hC;
  localparam logic [1:0] FMT_1B  = 2'd0;
  localparam logic [1:0] FMT_2B  = 2'd1;
  localparam logic [1:0] FMT_4B  = 2'd2;
  localparam logic [1:0] FMT_8B  = 2'd3;
endpackage

module exec_ctl
  import exec_ctl_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int W     = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_inst_valid,
  output logic          o_inst_ready,
  input  logic [15:0]   i_inst_word,
  output logic [3:0]    o_alu_inst,
  output logic [1:0]    o_alu_fmt,
  output logic [W-1:0]  o_alu_reg0,
  output logic [W-1:0]  o_alu_reg1,
  output logic [W-1:0]  o_alu_ram,
  input  logic [W-1:0]  i_alu_wb,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [W-1:0]  o_mem_addr,
  output logic [W-1:0]  o_mem_wdata,
  input  logic          i_mem_ack,
  input  logic [W-1:0]  i_mem_rdata,
  output logic          o_busy
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_MEM, S_EXEC} state_t;

  state_t        r_state;
  logic [3:0]    r_op;
  logic [1:0]    r_fmt;
  logic [3:0]    r_rd;
  logic [3:0]    r_rs;
  logic [W-1:0]  r_rf [NREGS];

  logic          w_is_mem;
  logic          w_writes_rd;
  logic          w_unused;

  assign w_is_mem    = (r_op == OP_LD) || (r_op == OP_LDA) || (r_op == OP_ST);
  // Stores, branches, specials and undefined opcodes all retire without touching rf.
  assign w_writes_rd = r_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                                    OP_SHL, OP_SHR, OP_MOV, OP_LD, OP_LDA};
  assign w_unused    = ^i_inst_word[9:8];

  assign o_inst_ready = (r_state == S_IDLE) && !i_rst;
  assign o_busy       = (r_state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_fmt       <= '0;
      r_rd        <= '0;
      r_rs        <= '0;
      for (int k = 0; k < NREGS; k++) r_rf[k] <= '0;
      o_alu_inst  <= '0;
      o_alu_fmt   <= '0;
      o_alu_reg0  <= '0;
      o_alu_reg1  <= '0;
      o_alu_ram   <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_inst_valid) begin
            r_op    <= i_inst_word[15:12];
            r_fmt   <= i_inst_word[11:10];
            r_rd    <= i_inst_word[7:4];
            r_rs    <= i_inst_word[3:0];
            r_state <= S_READ;
          end
        end
        S_READ: begin
          o_alu_inst <= r_op;
          o_alu_fmt  <= r_fmt;
          o_alu_reg0 <= r_rf[r_rs];
          o_alu_reg1 <= r_rf[r_rd];
          if (w_is_mem) begin
            o_mem_req  <= 1'b1;
            o_mem_we   <= (r_op == OP_ST);
            o_mem_addr <= (r_op == OP_LDA) ? (r_rf[r_rs] + r_rf[r_rd]) : r_rf[r_rs];
            if (r_op == OP_ST) o_mem_wdata <= r_rf[r_rd];
            r_state    <= S_MEM;
          end else begin
            r_state    <= S_EXEC;
          end
        end
        S_MEM: begin
          // Request fields stay frozen here until the memory acknowledges.
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            o_mem_we  <= 1'b0;
            if (r_op != OP_ST) o_alu_ram <= i_mem_rdata;
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_writes_rd) r_rf[r_rd] <= i_alu_wb;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exec_ctl.sv
// Bench for exec_ctl: directed scenarios plus randomized instruction streams checked
// against a transaction-level model of the register file and memory.
module tb_exec_ctl;
  import exec_ctl_pkg::*;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_ctl_if #(.W(W)) bus ();

  exec_ctl #(.NREGS(16), .W(W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_inst_valid(bus.inst_valid), .o_inst_ready(bus.inst_ready), .i_inst_word(bus.inst_word),
    .o_alu_inst(bus.alu_inst), .o_alu_fmt(bus.alu_fmt), .o_alu_reg0(bus.alu_reg0),
    .o_alu_reg1(bus.alu_reg1), .o_alu_ram(bus.alu_ram), .i_alu_wb(bus.alu_wb),
    .o_mem_req(bus.mem_req), .o_mem_we(bus.mem_we), .o_mem_addr(bus.mem_addr),
    .o_mem_wdata(bus.mem_wdata), .i_mem_ack(bus.mem_ack), .i_mem_rdata(bus.mem_rdata),
    .o_busy(bus.busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [W-1:0] rf_m [16];
  logic [W-1:0] mem_m [logic [W-1:0]];
  logic [W-1:0] exp_q [$];
  bit           exp_mem, exp_we;
  logic [W-1:0] exp_addr, exp_wdata;
  int           exp_lat;

  // Observations from the last driven instruction
  int           obs_lat, obs_req_cycles, obs_acc;
  bit           obs_stable, obs_timeout, obs_we;
  logic [W-1:0] obs_addr, obs_wdata;

  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [1:0] fmt,
                                          input logic [W-1:0] r0, input logic [W-1:0] r1,
                                          input logic [W-1:0] ram);
    logic [W-1:0] v;
    case (op)
      OP_ADD:        v = r1 + r0;
      OP_SUB:        v = r1 - r0;
      OP_AND:        v = r1 & r0;
      OP_OR:         v = r1 | r0;
      OP_XOR:        v = r1 ^ r0;
      OP_SHL:        v = r1 << r0[4:0];
      OP_SHR:        v = r1 >> r0[4:0];
      OP_MOV:        v = r0;
      OP_LD, OP_LDA: v = ram;
      default:       v = r1 ^ r0 ^ 32'hA5A5_0F0F;
    endcase
    case (fmt)
      FMT_1B:  v = v & 32'h0000_00FF;
      FMT_2B:  v = v & 32'h0000_FFFF;
      default: v = v;
    endcase
    return v;
  endfunction

  assign bus.alu_wb = alu_fn(bus.alu_inst, bus.alu_fmt, bus.alu_reg0, bus.alu_reg1, bus.alu_ram);

  function automatic logic [W-1:0] mem_rd(input logic [W-1:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  // Architectural effect of one instruction, derived from the instruction rules only.
  task automatic model_apply(input logic [15:0] w, input int n_mem);
    logic [3:0] op, rd, rs;
    logic [1:0] fmt;
    logic [W-1:0] a, b, ram;
    op = w[15:12]; fmt = w[11:10]; rd = w[7:4]; rs = w[3:0];
    a = rf_m[rs]; b = rf_m[rd];
    exp_mem   = (op == OP_LD) || (op == OP_LDA) || (op == OP_ST);
    exp_addr  = (op == OP_LDA) ? a + b : a;
    exp_we    = (op == OP_ST);
    exp_wdata = b;
    exp_lat   = exp_mem ? 3 + n_mem : 3;
    ram = mem_rd(exp_addr);
    if (op == OP_ST) mem_m[exp_addr] = b;
    if (op <= OP_LDA) rf_m[rd] = alu_fn(op, fmt, a, b, ram);
  endtask

  // Offers one instruction and plays the memory side; ack comes on the n_mem-th request cycle.
  task automatic run_inst(input logic [15:0] w, input int n_mem, input bit hold, input bit spur);
    bit first;
    obs_lat = 0; obs_req_cycles = 0; obs_acc = 0; obs_stable = 1'b1; obs_timeout = 1'b1;
    obs_we = 1'b0; obs_addr = '0; obs_wdata = '0; first = 1'b1;
    bus.inst_valid = 1'b1;
    bus.inst_word  = w;
    for (int c = 0; c < 200; c++) begin
      if (bus.inst_valid && bus.inst_ready) obs_acc++;
      @(posedge clk); #1;
      obs_lat++;
      bus.inst_valid = hold;
      bus.inst_word  = hold ? 16'($urandom) : w;
      bus.mem_ack    = 1'b0;
      bus.mem_rdata  = $urandom;
      if (bus.mem_req) begin
        obs_req_cycles++;
        if (first) begin
          obs_addr = bus.mem_addr; obs_we = bus.mem_we; obs_wdata = bus.mem_wdata; first = 1'b0;
        end else if (bus.mem_addr !== obs_addr || bus.mem_we !== obs_we ||
                     bus.mem_wdata !== obs_wdata) begin
          obs_stable = 1'b0;
        end
        if (obs_req_cycles == n_mem) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_rd(bus.mem_addr);
        end
      end else if (spur) begin
        bus.mem_ack = 1'($urandom_range(0, 1));
      end
      if (bus.inst_ready) begin
        obs_timeout = 1'b0;
        break;
      end
    end
    bus.inst_valid = 1'b0;
    bus.mem_ack    = 1'b0;
  endtask

  task automatic set_reg(input logic [3:0] k, input logic [W-1:0] v);
    logic [15:0] w;
    mem_m[32'h0] = v;
    w = {OP_LD, FMT_4B, 2'b00, k, 4'd0};
    model_apply(w, 1);
    run_inst(w, 1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.inst_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_low: got %b want 0", bus.inst_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if ({bus.mem_req, bus.mem_we} !== 2'b00) begin n_err++; $display("FAIL reset_mem_ctl: got %b want 00", {bus.mem_req, bus.mem_we}); end
    n_cmp++; if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin n_err++; $display("FAIL reset_mem_bus: got %h want 0", {bus.mem_addr, bus.mem_wdata}); end
    n_cmp++; if ({bus.alu_inst, bus.alu_fmt, bus.alu_reg0, bus.alu_reg1, bus.alu_ram} !== 102'h0) begin
      n_err++; $display("FAIL reset_alu_outs: got %h want 0", {bus.alu_inst, bus.alu_fmt, bus.alu_reg0, bus.alu_reg1, bus.alu_ram});
    end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.inst_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_release: got %b want 1", bus.inst_ready); end
    for (int k = 0; k < 16; k++) begin
      rf_m[k] = '0;
      n_cmp++; if (dut.r_rf[k] !== 32'h0) begin n_err++; $display("FAIL reset_rf[%0d]: got %h want 0", k, dut.r_rf[k]); end
    end
  endtask

  task automatic test_add();
    logic [15:0] w;
    set_reg(4'd1, 32'd5);
    set_reg(4'd2, 32'd7);
    w = {OP_ADD, FMT_4B, 2'b00, 4'd2, 4'd1};
    model_apply(w, 0);
    run_inst(w, 0, 1'b0, 1'b0);
    n_cmp++; if (obs_lat !== 3 || obs_timeout) begin n_err++; $display("FAIL add_latency: got %0d (timeout %b) want 3", obs_lat, obs_timeout); end
    n_cmp++; if (dut.r_rf[2] !== 32'd12) begin n_err++; $display("FAIL add_result: got %h want 0000000c", dut.r_rf[2]); end
    n_cmp++; if (obs_req_cycles !== 0) begin n_err++; $display("FAIL add_no_mem: got %0d req cycles want 0", obs_req_cycles); end
    n_cmp++; if (dut.r_rf[1] !== 32'd5) begin n_err++; $display("FAIL add_rs_kept: got %h want 00000005", dut.r_rf[1]); end
  endtask

  task automatic test_load();
    logic [15:0] w;
    set_reg(4'd3, 32'h100);
    mem_m[32'h100] = 32'hDEAD_BEEF;
    w = {OP_LD, FMT_4B, 2'b00, 4'd4, 4'd3};
    model_apply(w, 4);
    run_inst(w, 4, 1'b0, 1'b0);
    n_cmp++; if (obs_lat !== 7 || obs_timeout) begin n_err++; $display("FAIL ld_latency: got %0d (timeout %b) want 7", obs_lat, obs_timeout); end
    n_cmp++; if (obs_req_cycles !== 4) begin n_err++; $display("FAIL ld_req_cycles: got %0d want 4", obs_req_cycles); end
    n_cmp++; if (obs_addr !== 32'h100 || !obs_stable) begin n_err++; $display("FAIL ld_addr: got %h stable %b want 00000100 stable 1", obs_addr, obs_stable); end
    n_cmp++; if (obs_we !== 1'b0) begin n_err++; $display("FAIL ld_we: got %b want 0", obs_we); end
    n_cmp++; if (dut.r_rf[4] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ld_result: got %h want deadbeef", dut.r_rf[4]); end
  endtask

  task automatic test_store();
    logic [15:0] w;
    set_reg(4'd5, 32'h20);
    set_reg(4'd6, 32'hCAFE);
    w = {OP_ST, FMT_4B, 2'b00, 4'd6, 4'd5};
    model_apply(w, 2);
    run_inst(w, 2, 1'b0, 1'b0);
    n_cmp++; if (obs_req_cycles !== 2 || obs_lat !== 5) begin n_err++; $display("FAIL st_timing: got req %0d lat %0d want req 2 lat 5", obs_req_cycles, obs_lat); end
    n_cmp++; if (obs_addr !== 32'h20 || obs_wdata !== 32'hCAFE || obs_we !== 1'b1) begin
      n_err++; $display("FAIL st_write: got addr %h wdata %h we %b want 00000020 0000cafe 1", obs_addr, obs_wdata, obs_we);
    end
    n_cmp++; if (bus.mem_we !== 1'b0 || bus.mem_req !== 1'b0) begin n_err++; $display("FAIL st_clear: got req %b we %b want 0 0", bus.mem_req, bus.mem_we); end
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (dut.r_rf[k] !== rf_m[k]) begin n_err++; $display("FAIL st_rf[%0d]: got %h want %h", k, dut.r_rf[k], rf_m[k]); end
    end
  endtask

  task automatic test_lda_wrap();
    logic [15:0] w;
    set_reg(4'd7, 32'hFFFF_FFFF);
    set_reg(4'd8, 32'd2);
    w = {OP_LDA, FMT_4B, 2'b00, 4'd8, 4'd7};
    model_apply(w, 1);
    run_inst(w, 1, 1'b0, 1'b0);
    n_cmp++; if (obs_addr !== 32'h1) begin n_err++; $display("FAIL lda_wrap_addr: got %h want 00000001", obs_addr); end
    n_cmp++; if (obs_lat !== 4) begin n_err++; $display("FAIL lda_latency: got %0d want 4", obs_lat); end
    n_cmp++; if (dut.r_rf[8] !== mem_rd(32'h1)) begin n_err++; $display("FAIL lda_result: got %h want %h", dut.r_rf[8], mem_rd(32'h1)); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w1, w2;
    set_reg(4'd1, 32'd5);
    set_reg(4'd2, 32'd7);
    set_reg(4'd3, 32'd100);
    w1 = {OP_ADD, FMT_4B, 2'b00, 4'd2, 4'd1};
    w2 = {OP_SUB, FMT_4B, 2'b00, 4'd3, 4'd2};
    model_apply(w1, 0);
    run_inst(w1, 0, 1'b1, 1'b0);
    n_cmp++; if (obs_acc !== 1) begin n_err++; $display("FAIL b2b_accepts_1: got %0d want 1", obs_acc); end
    model_apply(w2, 0);
    run_inst(w2, 0, 1'b1, 1'b0);
    n_cmp++; if (obs_acc !== 1 || obs_lat !== 3) begin n_err++; $display("FAIL b2b_accepts_2: got acc %0d lat %0d want 1 3", obs_acc, obs_lat); end
    n_cmp++; if (dut.r_rf[2] !== 32'd12) begin n_err++; $display("FAIL b2b_add: got %h want 0000000c", dut.r_rf[2]); end
    n_cmp++; if (dut.r_rf[3] !== 32'd88) begin n_err++; $display("FAIL b2b_sub: got %h want 00000058", dut.r_rf[3]); end
  endtask

  task automatic test_reset_in_mem();
    set_reg(4'd9, 32'h300);
    mem_m[32'h300] = 32'h1234_5678;
    bus.inst_valid = 1'b1;
    bus.inst_word  = {OP_LD, FMT_4B, 2'b00, 4'd10, 4'd9};
    @(posedge clk); #1;
    bus.inst_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300) begin n_err++; $display("FAIL rstmem_req_pre: got req %b addr %h want 1 00000300", bus.mem_req, bus.mem_addr); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) rf_m[k] = '0;
    n_cmp++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmem_abort: got req %b busy %b want 0 0", bus.mem_req, bus.busy); end
    n_cmp++; if (bus.inst_ready !== 1'b0) begin n_err++; $display("FAIL rstmem_ready_in_rst: got %b want 0", bus.inst_ready); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.inst_ready !== 1'b1) begin n_err++; $display("FAIL rstmem_ready_after: got %b want 1", bus.inst_ready); end
    @(posedge clk); #1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    n_cmp++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.alu_ram !== 32'h0) begin
      n_err++; $display("FAIL rstmem_late_ack: got req %b busy %b ram %h want 0 0 0", bus.mem_req, bus.busy, bus.alu_ram);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (dut.r_rf[k] !== rf_m[k]) begin n_err++; $display("FAIL rstmem_rf[%0d]: got %h want %h", k, dut.r_rf[k], rf_m[k]); end
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    int nm;
    for (int k = 1; k < 16; k++) set_reg(4'(k), $urandom);
    for (int k = 0; k < 8; k++) mem_m[rf_m[$urandom_range(1, 15)]] = $urandom;
    for (int t = 0; t < 40; t++) begin
      w  = {4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      nm = $urandom_range(1, 5);
      model_apply(w, nm);
      if (exp_mem) exp_q.push_back(exp_addr);
      run_inst(w, nm, 1'($urandom_range(0, 1)), 1'b1);
      n_cmp++; if (obs_timeout || obs_lat !== exp_lat || obs_acc !== 1) begin
        n_err++; $display("FAIL rnd_timing[%0d]: got lat %0d acc %0d timeout %b want lat %0d acc 1", t, obs_lat, obs_acc, obs_timeout, exp_lat);
      end
      n_cmp++; if (obs_req_cycles !== (exp_mem ? nm : 0) || !obs_stable) begin
        n_err++; $display("FAIL rnd_mem_cycles[%0d]: got %0d stable %b want %0d", t, obs_req_cycles, obs_stable, exp_mem ? nm : 0);
      end
      if (exp_mem) begin
        n_cmp++; if (obs_addr !== exp_q.pop_front() || obs_we !== exp_we || (exp_we && obs_wdata !== exp_wdata)) begin
          n_err++; $display("FAIL rnd_mem_bus[%0d]: got addr %h we %b wdata %h want %h %b %h", t, obs_addr, obs_we, obs_wdata, exp_addr, exp_we, exp_wdata);
        end
      end
      for (int k = 0; k < 16; k++) begin
        n_cmp++; if (dut.r_rf[k] !== rf_m[k]) begin n_err++; $display("FAIL rnd_rf[%0d][%0d]: got %h want %h", t, k, dut.r_rf[k], rf_m[k]); end
      end
    end
  endtask

  initial begin
    bus.inst_valid = 1'b0;
    bus.inst_word  = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;
    test_reset();
    test_add();
    test_load();
    test_store();
    test_lda_wrap();
    test_back_to_back();
    test_reset_in_mem();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
